// File: rtl/ddr_rx_bitslip_align.sv
// DDR lane word aligner: slips the IOD until TRAIN_PATTERN repeats MATCH_CNT times; 1-cycle data latency once locked, no backpressure.
// Optional DDR_RX_ALIGN_STATUS_EN adds the SLIP_COUNT status output.
module ddr_rx_bitslip_align #(
  parameter logic [7:0] TRAIN_PATTERN = 8'h0F,
  parameter int         MATCH_CNT     = 8,
  parameter int         SLIP_WAIT     = 4,
  parameter int         MAX_SLIPS     = 8
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic [7:0] RX_DATA,
  input  logic       RX_DATA_VALID,
  input  logic       TRAIN_START,
  output logic       RX_BIT_SLIP,
  output logic       ALIGN_DONE,
  output logic       ALIGN_FAIL,
  output logic [7:0] DATA_OUT,
  output logic       DATA_VALID
`ifdef DDR_RX_ALIGN_STATUS_EN
  ,
  output logic [3:0] SLIP_COUNT
`endif
);

  typedef enum logic [2:0] {IDLE, CHECK, WAIT, LOCKED, FAIL} state_t;

  localparam logic [7:0] MATCH_LAST = 8'(MATCH_CNT - 1);
  localparam logic [3:0] SLIP_LIMIT = 4'(MAX_SLIPS);
  localparam logic [3:0] WAIT_LAST  = 4'(SLIP_WAIT - 1);

  state_t     state;
  logic [7:0] match_cnt;
  logic [3:0] slip_cnt;
  logic [3:0] wait_cnt;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state       <= IDLE;
      match_cnt   <= 8'h00;
      slip_cnt    <= 4'h0;
      wait_cnt    <= 4'h0;
      RX_BIT_SLIP <= 1'b0;
      ALIGN_DONE  <= 1'b0;
      ALIGN_FAIL  <= 1'b0;
      DATA_OUT    <= 8'h00;
      DATA_VALID  <= 1'b0;
    end else begin
      // Slip and data-valid are single-cycle unless re-asserted below.
      RX_BIT_SLIP <= 1'b0;
      DATA_VALID  <= 1'b0;
      if (TRAIN_START) begin
        state      <= CHECK;
        match_cnt  <= 8'h00;
        slip_cnt   <= 4'h0;
        wait_cnt   <= 4'h0;
        ALIGN_DONE <= 1'b0;
        ALIGN_FAIL <= 1'b0;
      end else begin
        case (state)
          CHECK: begin
            if (RX_DATA_VALID) begin
              if (RX_DATA == TRAIN_PATTERN) begin
                if (match_cnt >= MATCH_LAST) begin
                  state      <= LOCKED;
                  ALIGN_DONE <= 1'b1;
                end
                if (match_cnt != 8'hFF) match_cnt <= match_cnt + 8'd1;
              end else if (slip_cnt < SLIP_LIMIT) begin
                match_cnt   <= 8'h00;
                if (slip_cnt != 4'hF) slip_cnt <= slip_cnt + 4'd1;
                wait_cnt    <= 4'h0;
                RX_BIT_SLIP <= 1'b1;
                state       <= WAIT;
              end else begin
                state      <= FAIL;
                ALIGN_FAIL <= 1'b1;
              end
            end
          end
          WAIT: begin
            // Give the IOD time to settle after the slip before comparing again.
            if (wait_cnt >= WAIT_LAST) state <= CHECK;
            else wait_cnt <= wait_cnt + 4'd1;
          end
          LOCKED: begin
            DATA_OUT   <= RX_DATA;
            DATA_VALID <= RX_DATA_VALID;
          end
          IDLE, FAIL: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DDR_RX_ALIGN_STATUS_EN
  assign SLIP_COUNT = slip_cnt;
`endif

endmodule

// File: tb/tb_ddr_rx_bitslip_align.sv
// Bench for ddr_rx_bitslip_align: vector table, directed corner sequences, random run against a reference model.
module tb_ddr_rx_bitslip_align;

  localparam logic [7:0] PAT   = 8'h0F;
  localparam int         MATCH = 8;
  localparam int         SWAIT = 4;
  localparam int         MAXS  = 8;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       train_start;
  logic       rx_bit_slip;
  logic       align_done;
  logic       align_fail;
  logic [7:0] data_out;
  logic       data_valid;
`ifdef DDR_RX_ALIGN_STATUS_EN
  logic [3:0] slip_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddr_rx_bitslip_align #(
    .TRAIN_PATTERN(PAT),
    .MATCH_CNT(MATCH),
    .SLIP_WAIT(SWAIT),
    .MAX_SLIPS(MAXS)
  ) dut (
    .FAB_CLK(clk),
    .ARST_N(arst_n),
    .RX_DATA(rx_data),
    .RX_DATA_VALID(rx_vld),
    .TRAIN_START(train_start),
    .RX_BIT_SLIP(rx_bit_slip),
    .ALIGN_DONE(align_done),
    .ALIGN_FAIL(align_fail),
    .DATA_OUT(data_out),
    .DATA_VALID(data_valid)
`ifdef DDR_RX_ALIGN_STATUS_EN
    ,
    .SLIP_COUNT(slip_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ts, input logic v, input logic [7:0] d);
    train_start = ts;
    rx_vld      = v;
    rx_data     = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00);
    arst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] w;
    w = {x, x} << (n % 8);
    return w[15:8];
  endfunction

  // Reference model: tracks the alignment procedure as plain integers.
  localparam int M_IDLE = 0, M_CHECK = 1, M_WAIT = 2, M_LOCK = 3, M_FAIL = 4;
  int         m_mode, m_match, m_slips, m_wait_left;
  logic       e_slip, e_done, e_fail, e_dvld;
  logic [7:0] e_dout;

  task automatic model_reset();
    m_mode = M_IDLE; m_match = 0; m_slips = 0; m_wait_left = 0;
    e_slip = 1'b0; e_done = 1'b0; e_fail = 1'b0; e_dvld = 1'b0; e_dout = 8'h00;
  endtask

  task automatic model_tick(input logic ts, input logic v, input logic [7:0] d);
    e_slip = 1'b0;
    if (ts) begin
      m_mode = M_CHECK; m_match = 0; m_slips = 0;
      e_done = 1'b0; e_fail = 1'b0; e_dvld = 1'b0;
    end else begin
      e_dvld = (m_mode == M_LOCK) && v;
      if (m_mode == M_LOCK) e_dout = d;
      if (m_mode == M_CHECK && v) begin
        if (d == PAT) begin
          m_match++;
          if (m_match == MATCH) begin m_mode = M_LOCK; e_done = 1'b1; end
        end else if (m_slips < MAXS) begin
          m_match = 0; m_slips++; e_slip = 1'b1;
          m_mode = M_WAIT; m_wait_left = SWAIT;
        end else begin
          m_mode = M_FAIL; e_fail = 1'b1;
        end
      end else if (m_mode == M_WAIT) begin
        m_wait_left--;
        if (m_wait_left == 0) m_mode = M_CHECK;
      end
    end
  endtask

  typedef struct {
    logic       ts;
    logic       v;
    logic [7:0] d;
    logic       slip;
    logic       done;
    logic       fail;
    logic       dvld;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int slips, last, nv, bias;
    int m;
    logic ts, v;
    logic [7:0] d;

    // Table: idle ignore, start, 8 matches to lock, locked data path, restart, slip.
    tbl[0]  = '{1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    for (int i = 2; i < 9; i++)
      tbl[i] = '{1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C};
    tbl[11] = '{1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55};
    tbl[12] = '{1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
    tbl[13] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55};
    tbl[14] = '{1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};

    arst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("reset.slip", rx_bit_slip, 1'b0);
    check("reset.done", align_done, 1'b0);
    check("reset.fail", align_fail, 1'b0);
    check("reset.dout", data_out, 8'h00);
    check("reset.dvld", data_valid, 1'b0);
`ifdef DDR_RX_ALIGN_STATUS_EN
    check("reset.slip_count", slip_count, 4'h0);
`endif
    arst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].ts, tbl[i].v, tbl[i].d);
      @(negedge clk);
      check($sformatf("tbl%0d.slip", i), rx_bit_slip, tbl[i].slip);
      check($sformatf("tbl%0d.done", i), align_done, tbl[i].done);
      check($sformatf("tbl%0d.fail", i), align_fail, tbl[i].fail);
      check($sformatf("tbl%0d.dvld", i), data_valid, tbl[i].dvld);
      check($sformatf("tbl%0d.dout", i), data_out, tbl[i].dout);
    end

    // IOD misaligned by 3 bits; each slip rotates the word by one position.
    m = 3;
    drive(1'b1, 1'b1, rotl(PAT, m));
    @(negedge clk);
    slips = 0;
    last  = -100;
    for (int c = 0; c < 300 && !align_done; c++) begin
      drive(1'b0, 1'b1, rotl(PAT, m));
      @(negedge clk);
      if (rx_bit_slip) begin
        check($sformatf("offset3.slip_gap%0d", slips), (c - last) > SWAIT, 1'b1);
        slips++;
        last = c;
        if (m > 0) m--;
      end
    end
    check("offset3.done", align_done, 1'b1);
    check("offset3.fail", align_fail, 1'b0);
    check("offset3.slips", slips, 3);
`ifdef DDR_RX_ALIGN_STATUS_EN
    check("offset3.slip_count", slip_count, 4'd3);
`endif

    // Data stuck at zero: exhaust all slips, then fail without a further slip.
    drive(1'b1, 1'b1, 8'h00);
    @(negedge clk);
    slips = 0;
    for (int c = 0; c < 300 && !align_fail; c++) begin
      drive(1'b0, 1'b1, 8'h00);
      @(negedge clk);
      if (rx_bit_slip) slips++;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rx_bit_slip) slips++;
    end
    check("stuck.fail", align_fail, 1'b1);
    check("stuck.done", align_done, 1'b0);
    check("stuck.slips", slips, MAXS);
`ifdef DDR_RX_ALIGN_STATUS_EN
    check("stuck.slip_count", slip_count, 4'd8);
`endif

    // Valid toggling every cycle; invalid cycles carry garbage that must be ignored.
    drive(1'b1, 1'b1, PAT);
    @(negedge clk);
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      v = ((c % 2) == 0);
      drive(1'b0, v, v ? PAT : 8'h00);
      @(negedge clk);
      if (v) nv++;
      check($sformatf("toggle.done%0d", c), align_done, nv >= MATCH);
      check($sformatf("toggle.slip%0d", c), rx_bit_slip, 1'b0);
    end

    // Reset asserted while the block is in its post-slip wait.
    drive(1'b1, 1'b1, PAT);
    @(negedge clk);
    for (int c = 0; c < MATCH; c++) begin
      drive(1'b0, 1'b1, PAT);
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 8'h3C);
    @(negedge clk);
    check("rstwait.pre_dout", data_out, 8'h3C);
    drive(1'b1, 1'b1, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    check("rstwait.pre_slip", rx_bit_slip, 1'b1);
    arst_n = 1'b0;
    #1;
    check("rstwait.slip", rx_bit_slip, 1'b0);
    check("rstwait.done", align_done, 1'b0);
    check("rstwait.fail", align_fail, 1'b0);
    check("rstwait.dout", data_out, 8'h00);
    check("rstwait.dvld", data_valid, 1'b0);
`ifdef DDR_RX_ALIGN_STATUS_EN
    check("rstwait.slip_count", slip_count, 4'h0);
`endif
    @(negedge clk);
    arst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b1, 8'h00);
      @(negedge clk);
      check($sformatf("rstwait.idle_slip%0d", c), rx_bit_slip, 1'b0);
      check($sformatf("rstwait.idle_fail%0d", c), align_fail, 1'b0);
    end
    drive(1'b1, 1'b1, PAT);
    @(negedge clk);
    for (int c = 0; c < MATCH; c++) begin
      drive(1'b0, 1'b1, PAT);
      @(negedge clk);
      check($sformatf("rstwait.relock%0d", c), align_done, c == MATCH - 1);
    end

    // Randomized traffic checked cycle by cycle against the reference model.
    do_reset();
    model_reset();
    bias = 7;
    for (int c = 0; c < 4000; c++) begin
      ts = ($urandom_range(0, 39) == 0);
      if (ts) bias = $urandom_range(3, 10);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(1, 10) <= bias) ? PAT : 8'($urandom);
      drive(ts, v, d);
      model_tick(ts, v, d);
      @(negedge clk);
      check("rand.slip", rx_bit_slip, e_slip);
      check("rand.done", align_done, e_done);
      check("rand.fail", align_fail, e_fail);
      check("rand.dvld", data_valid, e_dvld);
      check("rand.dout", data_out, e_dout);
`ifdef DDR_RX_ALIGN_STATUS_EN
      check("rand.slip_count", slip_count, 4'(m_slips));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_rx_bitslip_align.md
DDR_RX_BITSLIP_ALIGN -- requirements
Module: ddr_rx_bitslip_align

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter TRAIN_PATTERN, default 8'h0F, the expected 8-bit training word; all 8 rotations of the default are distinct.
REQ-002 The block SHALL have parameter MATCH_CNT, default 8, the number of consecutive valid matching words required for lock (range 1-255).
REQ-003 The block SHALL have parameter SLIP_WAIT, default 4, the idle cycles after each slip pulse before words are compared again (range 1-15).
REQ-004 The block SHALL have parameter MAX_SLIPS, default 8, the number of slips allowed before failure (range 1-15).

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port FAB_CLK, input, 1, the single fabric clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port ARST_N, input, 1, an asynchronous active-low reset.
REQ-007 The block SHALL have port RX_DATA, input, 8, the deserialized word from the lane IOD.
REQ-008 The block SHALL have port RX_DATA_VALID, input, 1, the read-gate qualifier for RX_DATA.
REQ-009 The block SHALL have port TRAIN_START, input, 1, a one-cycle request to start or restart alignment.
REQ-010 The block SHALL have port RX_BIT_SLIP, output, 1, a one-cycle slip pulse driven to the IOD.
REQ-011 The block SHALL have port ALIGN_DONE, output, 1, lock achieved (level).
REQ-012 The block SHALL have port ALIGN_FAIL, output, 1, alignment exhausted (level).
REQ-013 The block SHALL have port DATA_OUT, output, 8, the aligned read word.
REQ-014 The block SHALL have port DATA_VALID, output, 1, the qualifier for DATA_OUT.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, CHECK, WAIT, LOCKED and FAIL.
REQ-016 In IDLE, a TRAIN_START pulse SHALL move the state to CHECK, clear the match and slip counters, and clear ALIGN_DONE and ALIGN_FAIL.
REQ-017 In CHECK, a cycle without RX_DATA_VALID SHALL hold all state and counters.
REQ-018 In CHECK, a valid word equal to TRAIN_PATTERN SHALL increment the match counter; when the counter reaches MATCH_CNT the state SHALL move to LOCKED and ALIGN_DONE SHALL be set on the next edge.
REQ-019 In CHECK, a valid mismatching word with slip counter < MAX_SLIPS SHALL clear the match counter, increment the slip counter, assert RX_BIT_SLIP for exactly one cycle, and move the state to WAIT.
REQ-020 In CHECK, a valid mismatching word with slip counter == MAX_SLIPS SHALL move the state to FAIL, set ALIGN_FAIL, and produce no slip pulse.
REQ-021 In WAIT, the block SHALL ignore RX_DATA for SLIP_WAIT cycles and then return to CHECK.
REQ-022 RX_BIT_SLIP SHALL never be asserted in two consecutive cycles and SHALL never be asserted outside the CHECK-to-WAIT transition.
REQ-023 In LOCKED, DATA_OUT SHALL be a register of RX_DATA and DATA_VALID SHALL be RX_DATA_VALID delayed by one cycle (1-cycle latency).
REQ-024 Outside LOCKED, DATA_VALID SHALL be 0 and DATA_OUT SHALL hold its last value.
REQ-025 In LOCKED and FAIL, the state SHALL be held until TRAIN_START.
REQ-026 TRAIN_START in any state SHALL take priority over every other event in the same cycle and SHALL restart the machine as in IDLE: counters cleared, flags cleared, DATA_VALID deasserted, and any pending wait aborted.
REQ-027 The counters SHALL saturate and never wrap.

Reset
REQ-028 Assertion of ARST_N (low) SHALL immediately force state IDLE, zero both counters, and drive RX_BIT_SLIP=0, ALIGN_DONE=0, ALIGN_FAIL=0, DATA_OUT=8'h00 and DATA_VALID=0, including in mid-operation.
REQ-029 Deassertion of ARST_N SHALL take effect on the next FAB_CLK edge, and the block SHALL remain in IDLE until TRAIN_START.

Configuration
REQ-030 When macro DDR_RX_ALIGN_STATUS_EN is defined, the block SHALL add output port SLIP_COUNT[3:0], equal to the current slip counter, which holds its final value in LOCKED or FAIL and is reset to 0.
REQ-031 When DDR_RX_ALIGN_STATUS_EN is undefined, port SLIP_COUNT and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL cover: RX_DATA=8'h0F valid continuously, then TRAIN_START -> zero slips, ALIGN_DONE high 8 valid cycles after CHECK is entered, SLIP_COUNT=0.
REQ-033 The bench SHALL cover: a model with IOD rotation offset 3 responding to RX_BIT_SLIP -> exactly 3 one-cycle slips, each spaced by at least 4 idle cycles, then lock with SLIP_COUNT=3.
REQ-034 The bench SHALL cover: RX_DATA stuck at 8'h00 -> 8 slips, then ALIGN_FAIL=1 with no 9th slip and ALIGN_DONE=0.
REQ-035 The bench SHALL cover: RX_DATA_VALID toggling 50% during CHECK -> the match counter advances only on valid cycles and lock occurs after 8 valid matches.
REQ-036 The bench SHALL cover: in LOCKED, RX_DATA=8'h3C with valid -> DATA_OUT=8'h3C and DATA_VALID=1 one cycle later; then TRAIN_START -> DATA_VALID=0 and ALIGN_DONE=0 on the next cycle.
REQ-037 The bench SHALL cover: ARST_N pulled low while in WAIT -> all outputs zero immediately and the state returns to IDLE.
